// File: rtl/rcvr_arbiter.sv
// rtl/rcvr_arbiter.sv - round-robin byte funnel from N_CH serial receivers; OVERRUN_CNT_EN adds per-channel overrun counters
module rcvr_arbiter #(
  parameter int N_CH = 4,
  parameter int CH_W = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_CH-1:0]   chan_en,
  input  logic [N_CH-1:0]   rx_ready,
  input  logic [N_CH-1:0]   rx_overrun,
  input  logic [8*N_CH-1:0] rx_data,
  output logic [N_CH-1:0]   rx_reading,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic [CH_W-1:0]   out_chan,
  output logic              out_ovr,
  input  logic              ovr_clr,
  output logic [8*N_CH-1:0] ovr_cnt
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t          r_state;
  logic [7:0]      r_out_data;
  logic [CH_W-1:0] r_out_chan;
  logic            r_out_ovr;
  logic [CH_W-1:0] r_ptr;

  logic [N_CH-1:0] w_req;
  logic            w_slot_free;
  logic            w_found;
  logic            w_take;
  logic [CH_W-1:0] w_grant;
  logic [CH_W-1:0] w_cand;
  logic [CH_W-1:0] w_next_ptr;
  logic [7:0]      w_byte;
  int              w_sum;

  assign w_req       = rx_ready & chan_en;
  // The slot can accept a new byte when empty or when the held byte leaves this cycle
  assign w_slot_free = (r_state == ST_EMPTY) | out_ready;
  assign w_take      = ~reset & w_slot_free & w_found;
  assign w_byte      = rx_data[{w_grant, 3'b000} +: 8];
  assign w_next_ptr  = (w_grant == CH_W'(N_CH - 1)) ? '0 : w_grant + 1'b1;

  // Round-robin scan: first requesting channel at or after r_ptr, wrapping to 0
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_sum   = 0;
    w_cand  = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_sum = int'(r_ptr) + k;
      if (w_sum >= N_CH) w_sum = w_sum - N_CH;
      w_cand = w_sum[CH_W-1:0];
      if (!w_found && w_req[w_cand]) begin
        w_found = 1'b1;
        w_grant = w_cand;
      end
    end
  end

  // One-hot read strobe to the granted receiver in the same cycle as the take
  always_comb begin
    rx_reading = '0;
    if (w_take) rx_reading[w_grant] = 1'b1;
  end

  // Output slot FSM with registered byte, channel tag and overrun flag
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_out_data <= '0;
      r_out_chan <= '0;
      r_out_ovr  <= 1'b0;
      r_ptr      <= '0;
    end else if (w_take) begin
      r_state    <= ST_FULL;
      r_out_data <= w_byte;
      r_out_chan <= w_grant;
      r_out_ovr  <= rx_overrun[w_grant];
      r_ptr      <= w_next_ptr;
    end else if (r_state == ST_FULL && out_ready) begin
      r_state <= ST_EMPTY;
    end
  end

  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;
  assign out_ovr   = r_out_ovr;

`ifdef OVERRUN_CNT_EN
  logic [7:0] r_ovr_cnt [N_CH];

  // Saturating per-channel overrun counters; clear has priority over increment
  always_ff @(posedge clock) begin
    if (reset || ovr_clr) begin
      for (int i = 0; i < N_CH; i++) r_ovr_cnt[i] <= '0;
    end else if (w_take && rx_overrun[w_grant] && r_ovr_cnt[w_grant] != 8'hFF) begin
      r_ovr_cnt[w_grant] <= r_ovr_cnt[w_grant] + 8'd1;
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_cnt_out
    assign ovr_cnt[8*gi +: 8] = r_ovr_cnt[gi];
  end
`else
  logic w_unused_ovr_clr;
  assign w_unused_ovr_clr = ovr_clr;
  assign ovr_cnt          = '0;
`endif

endmodule

// File: tb/tb_rcvr_arbiter.sv
// tb/tb_rcvr_arbiter.sv - table-driven bench for rcvr_arbiter
module tb_rcvr_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  chan_en, rx_ready, rx_overrun, rx_reading;
  logic [31:0] rx_data, ovr_cnt;
  logic        out_valid, out_ready, out_ovr, ovr_clr;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  rcvr_arbiter #(.N_CH(4), .CH_W(2)) dut (
    .clock(clock), .reset(reset), .chan_en(chan_en), .rx_ready(rx_ready),
    .rx_overrun(rx_overrun), .rx_data(rx_data), .rx_reading(rx_reading),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_chan(out_chan), .out_ovr(out_ovr), .ovr_clr(ovr_clr), .ovr_cnt(ovr_cnt)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  en;
    logic [3:0]  rdy;
    logic [3:0]  ovr;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  e_rd;
    logic        e_v;
    logic [7:0]  e_d;
    logic [1:0]  e_c;
    logic        e_o;
  } vec_t;

  vec_t vecs[22];

  localparam logic [31:0] D  = 32'hD3C2B1A0;
  localparam logic [31:0] D1 = 32'hD3C23CA0;

`ifdef OVERRUN_CNT_EN
  localparam logic [7:0] CNT_ONE = 8'd1;
  localparam logic [7:0] CNT_SAT = 8'd255;
`else
  localparam logic [7:0] CNT_ONE = 8'd0;
  localparam logic [7:0] CNT_SAT = 8'd0;
`endif

  function automatic vec_t mk(logic rst, logic [3:0] en, logic [3:0] rdy, logic [3:0] ovr,
                              logic [31:0] data, logic ordy, logic [3:0] e_rd, logic e_v,
                              logic [7:0] e_d, logic [1:0] e_c, logic e_o);
    vec_t r;
    r.rst = rst; r.en = en; r.rdy = rdy; r.ovr = ovr; r.data = data; r.ordy = ordy;
    r.e_rd = e_rd; r.e_v = e_v; r.e_d = e_d; r.e_c = e_c; r.e_o = e_o;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                         input logic [1:0] c, input logic o);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
    if (v) begin
      chk({tag, ".out_data"}, {24'd0, out_data}, {24'd0, d});
      chk({tag, ".out_chan"}, {30'd0, out_chan}, {30'd0, c});
      chk({tag, ".out_ovr"},  {31'd0, out_ovr},  {31'd0, o});
    end
  endtask

  initial begin
    reset = 1'b1; chan_en = 4'hF; rx_ready = '0; rx_overrun = '0; rx_data = D;
    out_ready = 1'b1; ovr_clr = 1'b0;

    //       rst en    rdy   ovr   data ordy  e_rd  v  data   ch  ovr
    vecs[0]  = mk(1, 4'hF, 4'hF, 4'h0, D,  1, 4'h0, 0, 8'h00, 0, 0);
    vecs[1]  = mk(0, 4'hF, 4'h2, 4'h0, D1, 1, 4'h2, 0, 8'h00, 0, 0);
    vecs[2]  = mk(0, 4'hF, 4'h0, 4'h0, D1, 1, 4'h0, 1, 8'h3C, 1, 0);
    vecs[3]  = mk(1, 4'hF, 4'h0, 4'h0, D,  1, 4'h0, 0, 8'h00, 0, 0);
    vecs[4]  = mk(0, 4'hF, 4'hF, 4'h0, D,  1, 4'h1, 0, 8'h00, 0, 0);
    vecs[5]  = mk(0, 4'hF, 4'hF, 4'h0, D,  1, 4'h2, 1, 8'hA0, 0, 0);
    vecs[6]  = mk(0, 4'hF, 4'hF, 4'h0, D,  1, 4'h4, 1, 8'hB1, 1, 0);
    vecs[7]  = mk(0, 4'hF, 4'hF, 4'h0, D,  1, 4'h8, 1, 8'hC2, 2, 0);
    vecs[8]  = mk(0, 4'hF, 4'hF, 4'h0, D,  1, 4'h1, 1, 8'hD3, 3, 0);
    vecs[9]  = mk(0, 4'hB, 4'h4, 4'h0, D,  1, 4'h0, 1, 8'hA0, 0, 0);
    vecs[10] = mk(0, 4'hB, 4'h4, 4'h0, D,  1, 4'h0, 0, 8'h00, 0, 0);
    vecs[11] = mk(0, 4'hF, 4'h4, 4'h4, D,  1, 4'h4, 0, 8'h00, 0, 0);
    vecs[12] = mk(0, 4'hF, 4'h0, 4'h0, D,  1, 4'h0, 1, 8'hC2, 2, 1);
    vecs[13] = mk(0, 4'hF, 4'h9, 4'h0, D,  1, 4'h8, 0, 8'h00, 0, 0);
    vecs[14] = mk(0, 4'hF, 4'h9, 4'h0, D,  1, 4'h1, 1, 8'hD3, 3, 0);
    vecs[15] = mk(0, 4'hF, 4'h9, 4'h0, D,  0, 4'h0, 1, 8'hA0, 0, 0);
    vecs[16] = mk(0, 4'hF, 4'h9, 4'h0, D,  0, 4'h0, 1, 8'hA0, 0, 0);
    vecs[17] = mk(0, 4'hF, 4'h9, 4'h0, D,  1, 4'h8, 1, 8'hA0, 0, 0);
    vecs[18] = mk(0, 4'hF, 4'h0, 4'h0, D,  0, 4'h0, 1, 8'hD3, 3, 0);
    vecs[19] = mk(1, 4'hF, 4'hF, 4'h0, D,  1, 4'h0, 1, 8'hD3, 3, 0);
    vecs[20] = mk(0, 4'hF, 4'h0, 4'h0, D,  1, 4'h0, 0, 8'h00, 0, 0);
    vecs[21] = mk(0, 4'hF, 4'hF, 4'h0, D,  1, 4'h1, 0, 8'h00, 0, 0);

    repeat (3) step();
    chk_out("reset", 1'b0, 8'h00, 2'd0, 1'b0);
    chk("reset.out_data", {24'd0, out_data}, 32'd0);
    chk("reset.out_chan", {30'd0, out_chan}, 32'd0);
    chk("reset.out_ovr", {31'd0, out_ovr}, 32'd0);
    chk("reset.ovr_cnt", ovr_cnt, 32'd0);

    for (int i = 0; i < 22; i++) begin
      if (i != 0) step();
      reset = vecs[i].rst; chan_en = vecs[i].en; rx_ready = vecs[i].rdy;
      rx_overrun = vecs[i].ovr; rx_data = vecs[i].data; out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("row%0d.rx_reading", i), {28'd0, rx_reading}, {28'd0, vecs[i].e_rd});
      chk_out($sformatf("row%0d", i), vecs[i].e_v, vecs[i].e_d, vecs[i].e_c, vecs[i].e_o);
    end

    // Back-pressure: held byte A0/ch0 stays put for 5 cycles, then ch0 regranted
    step();
    rx_data = 32'hD3C2B155; rx_ready = 4'h1; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("stall%0d.rx_reading", i), {28'd0, rx_reading}, 32'd0);
      chk_out($sformatf("stall%0d", i), 1'b1, 8'hA0, 2'd0, 1'b0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("release.rx_reading", {28'd0, rx_reading}, 32'h1);
    chk_out("release", 1'b1, 8'hA0, 2'd0, 1'b0);
    step();
    rx_ready = 4'h0;
    #1;
    chk_out("release_next", 1'b1, 8'h55, 2'd0, 1'b0);

    // Overrun tagging and counter saturation on channel 2
    step();
    rx_data = D; rx_ready = 4'h4; rx_overrun = 4'h4;
    step();
    chk_out("ovr_first", 1'b1, 8'hC2, 2'd2, 1'b1);
    chk("ovr_first.cnt2", {24'd0, ovr_cnt[23:16]}, {24'd0, CNT_ONE});
    repeat (299) step();
    chk("ovr_sat.cnt2", {24'd0, ovr_cnt[23:16]}, {24'd0, CNT_SAT});
    chk("ovr_sat.cnt_other", {8'd0, ovr_cnt[31:24], ovr_cnt[15:0]}, 32'd0);
    ovr_clr = 1'b1;
    step();
    chk("ovr_clr.cnt", ovr_cnt, 32'd0);
    ovr_clr = 1'b0; rx_ready = 4'h0; rx_overrun = 4'h0;
    step();
    chk("after_clr.cnt", ovr_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
